uart_rx_8n1: RTL

- Serial UART receiver that sits directly upstream of the stopwatch command FSM.
- Samples the asynchronous `rx` pin with 16x oversampling and deframes 8N1 characters (LSB first).
- Presents each good byte on `o_rx_data` with a single-cycle `o_rx_done` strobe; these are the FSM's `i_rx_data` / `i_rx_done` inputs.
- Also reports framing errors and, optionally, parity errors.

---
 rtl/uart_rx_8n1.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_8n1.sv
// 16x-oversampled 8N1 UART receiver feeding the stopwatch command FSM.
// Define UART_RX_PARITY_EN to add one even-parity bit between the data and stop bits.
module uart_rx_8n1 #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] o_rx_data,
  output logic       o_rx_done,
  output logic       o_rx_busy,
  output logic       o_frame_err,
  output logic       o_parity_err
);

  localparam int DIV = CLK_FREQ / (BAUD * OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVS);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;
`endif

  logic [1:0]    r_sync;
  logic [DW-1:0] r_div;
  state_t        r_state, w_nstate;
  logic [TW-1:0] r_tcnt, w_ntcnt;
  logic [2:0]    r_idx, w_nidx;
  logic [7:0]    r_shift, w_nshift;
  logic [7:0]    r_data, w_ndata;
  logic          r_done, w_ndone;
  logic          r_ferr, w_nferr;
`ifdef UART_RX_PARITY_EN
  logic          r_perr, w_nperr;
  logic          r_par_bad, w_npar_bad;
`endif

  logic w_rxs, w_tick, w_mid, w_bit_end;

  assign w_rxs     = r_sync[1];
  assign w_tick    = (r_div == DW'(DIV - 1));
  assign w_mid     = w_tick && (r_tcnt == TW'(OVS / 2 - 1));
  assign w_bit_end = w_tick && (r_tcnt == TW'(OVS - 1));

  // Synchronizer presets to 1 so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b11;
      r_div  <= '0;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_div  <= w_tick ? '0 : r_div + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_tcnt    <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_state   <= w_nstate;
      r_tcnt    <= w_ntcnt;
      r_idx     <= w_nidx;
      r_shift   <= w_nshift;
      r_data    <= w_ndata;
      r_done    <= w_ndone;
      r_ferr    <= w_nferr;
`ifdef UART_RX_PARITY_EN
      r_perr    <= w_nperr;
      r_par_bad <= w_npar_bad;
`endif
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ntcnt  = r_tcnt;
    w_nidx   = r_idx;
    w_nshift = r_shift;
    w_ndata  = r_data;
    w_ndone  = 1'b0;
    w_nferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_nperr    = 1'b0;
    w_npar_bad = r_par_bad;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_rxs) begin
          w_nstate = S_START;
          w_ntcnt  = '0;
        end
      end
      S_START: begin
        if (w_mid) begin
          if (w_rxs) begin
            w_nstate = S_IDLE;
          end else begin
            w_nstate = S_DATA;
            w_ntcnt  = '0;
            w_nidx   = '0;
          end
        end else if (w_tick) begin
          w_ntcnt = r_tcnt + TW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_nshift[r_idx] = w_rxs;
          w_ntcnt         = '0;
          w_nidx          = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_nstate = S_PARITY;
`else
            w_nstate = S_STOP;
`endif
          end
        end else if (w_tick) begin
          w_ntcnt = r_tcnt + TW'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_npar_bad = w_rxs ^ (^r_shift);
          w_ntcnt    = '0;
          w_nstate   = S_STOP;
        end else if (w_tick) begin
          w_ntcnt = r_tcnt + TW'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_ntcnt = '0;
          if (w_rxs) begin
            w_nstate = S_IDLE;
`ifdef UART_RX_PARITY_EN
            // Parity error is held back to the stop sample so a bad stop bit wins.
            if (r_par_bad) begin
              w_nperr = 1'b1;
            end else begin
              w_ndone = 1'b1;
              w_ndata = r_shift;
            end
`else
            w_ndone = 1'b1;
            w_ndata = r_shift;
`endif
          end else begin
            w_nferr  = 1'b1;
            w_nstate = S_WAIT_HIGH;
          end
        end else if (w_tick) begin
          w_ntcnt = r_tcnt + TW'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (w_rxs) w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  assign o_rx_data   = r_data;
  assign o_rx_done   = r_done;
  assign o_rx_busy   = (r_state != S_IDLE);
  assign o_frame_err = r_ferr;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_perr;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule
